// File: rtl/monitor_pkg.sv
// Shared types, default sizes and helpers for the timing-monitor control loop.
package monitor_pkg;

   localparam int N_MON_DEF      = 8;
   localparam int CNT_W_DEF      = 16;
   localparam int TAP_W_DEF      = 4;
   localparam int SETTLE_CYC_DEF = 4;

   // Widest monitor array the popcount helper handles, and its result width
   localparam int MON_MAX = 64;
   localparam int PC_W    = 7;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      EVAL,
      DECIDE,
      REQ,
      SETTLE
   } state_t;

   // Counts set bits among the lowest n_mon bits of a zero-extended vector
   function automatic logic [PC_W-1:0] popcount(input logic [MON_MAX-1:0] vec, input int n_mon);
      logic [PC_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < MON_MAX; i++) begin
         if ((i < n_mon) && vec[i]) begin
            cnt = cnt + PC_W'(1);
         end
      end
      return cnt;
   endfunction

endpackage

// File: rtl/monitor_ctrl_if.sv
// Tap-change request/acknowledge handshake between the controller and the clock/DVFS owner.
interface monitor_ctrl_if;

   logic adj_req;
   logic adj_dir;
   logic adj_ack;

   modport master (
      output adj_req,
      output adj_dir,
      input  adj_ack
   );

   modport slave (
      input  adj_req,
      input  adj_dir,
      output adj_ack
   );

endinterface

// File: rtl/monitor_ctrl_warn_sync.sv
// Two-flop synchronizer bringing the asynchronous monitor warnings into the clk domain.
module warn_sync #(
   parameter int N_MON = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_MON-1:0] async_in,
   output logic [N_MON-1:0] sync_out
);

   logic [N_MON-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta     <= '0;
         sync_out <= '0;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/monitor_ctrl.sv
// Closed-loop controller: counts masked monitor warnings per evaluation window and
// requests delay-line tap moves over the adj req/ack handshake.
module monitor_ctrl
   import monitor_pkg::*;
#(
   parameter int N_MON      = N_MON_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int TAP_W      = TAP_W_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [CNT_W-1:0] eval_period,
   input  logic [CNT_W-1:0] warn_thresh,
   input  logic [N_MON-1:0] mon_mask,
   input  logic [N_MON-1:0] warning_in,
   output logic             detec_en,
   output logic [TAP_W-1:0] tap_sel,
   output logic [CNT_W-1:0] last_count,
   output logic             tap_sat,
   output logic             busy,
   monitor_ctrl_if.master   adj
);

   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam int ST_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [TAP_W-1:0] TAP_MAX = '1;

   state_t state_q, state_d;

   logic [N_MON-1:0] warn_synced;
   logic [N_MON-1:0] warn_s;
   logic [PC_W-1:0]  warn_pop;
   logic [SUM_W-1:0] warn_sum;
   logic [CNT_W-1:0] warn_next;
   logic [CNT_W-1:0] warn_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] period_eff;
   logic [ST_W-1:0]  settle_cnt;
   logic             period_last;
   logic             settle_last;
   logic             want_up;
   logic             want_down;
   logic             dir_q;

   warn_sync #(.N_MON(N_MON)) u_warn_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (warning_in),
      .sync_out (warn_synced)
   );

   // Saturating per-cycle accumulation of the masked, synchronized warnings
   assign warn_s      = warn_synced & mon_mask;
   assign warn_pop    = popcount(MON_MAX'(warn_s), N_MON);
   assign warn_sum    = SUM_W'(warn_cnt) + SUM_W'(warn_pop);
   assign warn_next   = (warn_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : warn_sum[CNT_W-1:0];

   assign period_eff  = (eval_period == '0) ? CNT_W'(1) : eval_period;
   assign period_last = (period_cnt == (period_eff - CNT_W'(1)));
   assign settle_last = (settle_cnt == ST_W'(SETTLE_CYC - 1));
   assign want_up     = (warn_cnt > warn_thresh);
   assign want_down   = (warn_cnt == '0);

   assign detec_en    = (state_q == EVAL);
   assign busy        = (state_q != IDLE);
   assign adj.adj_req = (state_q == REQ);
   assign adj.adj_dir = dir_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Dropping enable wins over every transition, including a pending ack
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    state_d = ARM;
            ARM:     state_d = EVAL;
            EVAL:    if (period_last) state_d = DECIDE;
            DECIDE: begin
               if (want_up && (tap_sel != TAP_MAX)) begin
                  state_d = REQ;
               end else if (want_down && (tap_sel != '0)) begin
                  state_d = REQ;
               end else begin
                  state_d = ARM;
               end
            end
            REQ:     if (adj.adj_ack) state_d = SETTLE;
            SETTLE:  if (settle_last) state_d = ARM;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warn_cnt   <= '0;
         period_cnt <= '0;
         settle_cnt <= '0;
         last_count <= '0;
         tap_sel    <= '0;
         tap_sat    <= 1'b0;
         dir_q      <= 1'b0;
      end else if (enable) begin
         unique case (state_q)
            IDLE: tap_sat <= 1'b0;
            ARM: begin
               warn_cnt   <= '0;
               period_cnt <= '0;
            end
            EVAL: begin
               warn_cnt   <= warn_next;
               period_cnt <= period_cnt + CNT_W'(1);
            end
            DECIDE: begin
               last_count <= warn_cnt;
               if (want_up) begin
                  if (tap_sel == TAP_MAX) tap_sat <= 1'b1;
                  else                    dir_q   <= 1'b1;
               end else if (want_down) begin
                  if (tap_sel == '0) tap_sat <= 1'b1;
                  else               dir_q   <= 1'b0;
               end
            end
            REQ: begin
               if (adj.adj_ack) begin
                  tap_sel    <= dir_q ? (tap_sel + TAP_W'(1)) : (tap_sel - TAP_W'(1));
                  settle_cnt <= '0;
               end
            end
            SETTLE: settle_cnt <= settle_cnt + ST_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_monitor_ctrl.sv
// Directed plus randomized bench for monitor_ctrl, checked against a window-level model.
module tb_monitor_ctrl;

   localparam int SETTLE_CYC = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] eval_period = '0;
   logic [15:0] warn_thresh = '0;
   logic [7:0]  mon_mask = '0;
   logic [7:0]  warning_in = '0;
   logic        detec_en;
   logic [3:0]  tap_sel;
   logic [15:0] last_count;
   logic        tap_sat;
   logic        busy;

   logic        enable2 = 1'b0;
   logic [3:0]  eval_period2 = '0;
   logic [3:0]  warn_thresh2 = '0;
   logic [7:0]  mon_mask2 = '0;
   logic [7:0]  warning_in2 = '0;
   logic        detec_en2;
   logic [3:0]  tap_sel2;
   logic [3:0]  last_count2;
   logic        tap_sat2;
   logic        busy2;

   int checks = 0;
   int errors = 0;
   int model_tap = 0;
   bit model_sat = 1'b0;

   monitor_ctrl_if bus ();
   monitor_ctrl_if bus2 ();

   monitor_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .eval_period (eval_period),
      .warn_thresh (warn_thresh),
      .mon_mask    (mon_mask),
      .warning_in  (warning_in),
      .detec_en    (detec_en),
      .tap_sel     (tap_sel),
      .last_count  (last_count),
      .tap_sat     (tap_sat),
      .busy        (busy),
      .adj         (bus)
   );

   // Narrow counters to exercise warning-count saturation
   monitor_ctrl #(.CNT_W(4)) dut_sat (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable2),
      .eval_period (eval_period2),
      .warn_thresh (warn_thresh2),
      .mon_mask    (mon_mask2),
      .warning_in  (warning_in2),
      .detec_en    (detec_en2),
      .tap_sel     (tap_sel2),
      .last_count  (last_count2),
      .tap_sat     (tap_sat2),
      .busy        (busy2),
      .adj         (bus2)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int popc(input logic [7:0] v);
      int c = 0;
      for (int i = 0; i < 8; i++) c += int'(v[i]);
      return c;
   endfunction

   task automatic check_reset_state();
      check_output("rst_detec_en", 32'(detec_en), 0);
      check_output("rst_tap_sel", 32'(tap_sel), 0);
      check_output("rst_adj_req", 32'(bus.adj_req), 0);
      check_output("rst_adj_dir", 32'(bus.adj_dir), 0);
      check_output("rst_last_count", 32'(last_count), 0);
      check_output("rst_tap_sat", 32'(tap_sat), 0);
      check_output("rst_busy", 32'(busy), 0);
   endtask

   // Called in the ARM cycle; warning_in must already hold w. Returns in the next ARM cycle.
   task automatic run_window(input int period, input int thresh, input logic [7:0] mask,
                             input logic [7:0] w, input int n_hi, input int ack_delay,
                             input logic [7:0] next_w);
      int p_eff;
      int cnt;
      bit up;
      bit down;
      p_eff = (period == 0) ? 1 : period;
      eval_period = 16'(period);
      warn_thresh = 16'(thresh);
      mon_mask = mask;
      cnt = ((n_hi > p_eff) ? p_eff : n_hi) * popc(w & mask);
      if (cnt > 65535) cnt = 65535;
      check_output("arm_detec_en", 32'(detec_en), 0);
      for (int i = 0; i < p_eff; i++) begin
         tick(1);
         if (i == 0) check_output("eval_detec_en", 32'(detec_en), 1);
         if ((n_hi < p_eff) && (i == n_hi - 2)) warning_in = '0;
      end
      tick(1);
      check_output("decide_detec_en", 32'(detec_en), 0);
      warning_in = next_w;
      tick(1);
      check_output("last_count", 32'(last_count), 32'(cnt));
      up = (cnt > thresh);
      down = (cnt == 0);
      if ((up && model_tap == 15) || (down && model_tap == 0)) model_sat = 1'b1;
      check_output("tap_sat", 32'(tap_sat), 32'(model_sat));
      if ((up && model_tap < 15) || (down && model_tap > 0)) begin
         check_output("adj_req_high", 32'(bus.adj_req), 1);
         check_output("adj_dir", 32'(bus.adj_dir), 32'(up));
         tick(ack_delay);
         bus.adj_ack = 1'b1;
         tick(1);
         bus.adj_ack = 1'b0;
         model_tap = up ? model_tap + 1 : model_tap - 1;
         check_output("tap_after_ack", 32'(tap_sel), 32'(model_tap));
         check_output("adj_req_dropped", 32'(bus.adj_req), 0);
         check_output("settle_detec_en", 32'(detec_en), 0);
         tick(SETTLE_CYC);
      end else begin
         check_output("no_adj_req", 32'(bus.adj_req), 0);
         check_output("tap_unchanged", 32'(tap_sel), 32'(model_tap));
      end
      check_output("arm_busy", 32'(busy), 1);
   endtask

   initial begin
      logic [7:0] cur_w;
      logic [7:0] nxt_w;
      bus.adj_ack = 1'b0;
      bus2.adj_ack = 1'b0;
      tick(2);
      check_reset_state();
      rst_n = 1'b1;
      tick(2);

      // Saturation on the narrow instance: 8 warnings x 3 cycles caps at 15
      warning_in2 = 8'hFF;
      mon_mask2 = 8'hFF;
      eval_period2 = 4'd3;
      warn_thresh2 = 4'd15;
      tick(3);
      enable2 = 1'b1;
      tick(6);
      check_output("sat_last_count", 32'(last_count2), 15);
      check_output("sat_no_req", 32'(bus2.adj_req), 0);
      enable2 = 1'b0;

      // Directed loop from IDLE
      warning_in = 8'h01;
      enable = 1'b1;
      tick(1);
      model_sat = 1'b0;
      run_window(10, 3, 8'hFF, 8'h01, 5, 2, 8'hFF);
      run_window(4, 3, 8'hFF, 8'hFF, 4, 0, 8'h00);
      run_window(8, 3, 8'hFF, 8'h00, 8, 1, 8'h00);
      run_window(8, 3, 8'hFF, 8'h00, 8, 0, 8'h00);
      run_window(8, 3, 8'hFF, 8'h00, 8, 0, 8'hFF);
      run_window(4, 100, 8'h0F, 8'hFF, 4, 0, 8'h01);
      cur_w = 8'($urandom);
      run_window(0, 5, 8'hFF, 8'h01, 1, 0, cur_w);

      for (int k = 0; k < 10; k++) begin
         nxt_w = (k == 9) ? 8'h00 : 8'($urandom);
         run_window(int'($urandom_range(1, 12)), int'($urandom_range(0, 40)), 8'($urandom),
                    cur_w, 64, int'($urandom_range(0, 3)), nxt_w);
         cur_w = nxt_w;
      end

      // Leaving through IDLE keeps tap_sat; the next ARM entry clears it
      enable = 1'b0;
      tick(1);
      check_output("idle_busy", 32'(busy), 0);
      check_output("idle_tap_sat_kept", 32'(tap_sat), 32'(model_sat));
      check_output("idle_tap_kept", 32'(tap_sel), 32'(model_tap));
      tick(2);
      enable = 1'b1;
      tick(1);
      check_output("rearm_tap_sat_clear", 32'(tap_sat), 0);
      tick(3);
      check_output("mid_eval_detec_en", 32'(detec_en), 1);
      rst_n = 1'b0;
      #1;
      check_reset_state();
      model_tap = 0;
      enable = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(2);
      check_output("post_rst_busy", 32'(busy), 0);

      // Enable falls in REQ together with an ack: ack must be ignored
      warning_in = 8'hFF;
      mon_mask = 8'hFF;
      eval_period = 16'd4;
      warn_thresh = 16'd0;
      enable = 1'b1;
      tick(7);
      check_output("drop_req_pending", 32'(bus.adj_req), 1);
      enable = 1'b0;
      bus.adj_ack = 1'b1;
      tick(1);
      bus.adj_ack = 1'b0;
      warning_in = '0;
      check_output("drop_busy", 32'(busy), 0);
      check_output("drop_adj_req", 32'(bus.adj_req), 0);
      check_output("drop_tap_sel", 32'(tap_sel), 32'(model_tap));
      check_output("drop_detec_en", 32'(detec_en), 0);
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
